// File: rtl/axis_pkg.sv
// Shared types for the AXI-stream frame length policer: FSM state encoding
// and the per-frame status flags that travel with the frame length.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic truncated;
    logic runt;
    logic bad;
  } status_flags_t;

  localparam status_flags_t FLAGS_CLEAR = 3'b000;

  // Assemble a status flag record from its individual conditions.
  function automatic status_flags_t make_flags(input logic truncated,
                                               input logic runt,
                                               input logic bad);
    status_flags_t f;
    f.truncated = truncated;
    f.runt      = runt;
    f.bad       = bad;
    return f;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Registered valid/ready pass-through: one output register plus one skid
// entry, so the upstream ready is a flop and a stalled output never loses
// the beat that was in flight when ready dropped.
module axis_skid_reg #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q;
  logic             push;

  // Next-state of output register and skid entry.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    push         = in_valid_i & ready_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees this cycle: the oldest beat (skid first) moves in.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      // Output stalled: a beat accepted now parks in the skid entry.
      if (push) begin
        skid_data_d  = in_data_i;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Pipeline registers; ready is registered as "skid entry will be empty".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q   <= {WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      skid_data_q  <= {WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_frame_len_check.sv
// AXI-stream frame length policer. Beats pass through a skid register while
// a beat counter tracks frame length; over-long frames are cut at MAX_LEN
// (forced tlast+tuser, remainder dropped), short frames are flagged, and a
// single-entry status slot reports each completed frame.
module axis_frame_len_check
  import axis_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MIN_LEN    = 2,
  parameter  int unsigned MAX_LEN    = 16,
  localparam int unsigned LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  status_valid,
  input  logic                  status_ready,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_truncated,
  output logic                  status_runt,
  output logic                  status_bad
);

  localparam logic [LEN_WIDTH-1:0] ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    status_flags_t        flags;
  } status_t;

  fsm_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  status_t              status_q, status_d;
  logic                 status_valid_q, status_valid_d;

  logic                 in_drop, hit_max, frame_end, status_blocked;
  logic                 accept, trunc_beat, is_runt, fwd_last, fwd_user;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 skid_ready;
  logic [DATA_WIDTH+1:0] skid_out;

  // Beat classification and upstream ready (frame-ending beats wait for the status slot).
  always_comb begin
    in_drop        = (state_q == ST_DROP);
    cnt_inc        = (state_q == ST_IDLE) ? ONE : (cnt_q + ONE);
    hit_max        = ~in_drop & (cnt_inc == MAX_L);
    frame_end      = input_axis_tlast | hit_max;
    status_blocked = status_valid_q & ~status_ready;
    input_axis_tready = rst_n & ~(frame_end & status_blocked) & (in_drop | skid_ready);
    accept         = input_axis_tvalid & input_axis_tready;
    trunc_beat     = hit_max & ~input_axis_tlast;
    is_runt        = (cnt_inc < MIN_L);
    fwd_last       = input_axis_tlast | trunc_beat;
    fwd_user       = fwd_last ? (input_axis_tuser | is_runt | trunc_beat) : input_axis_tuser;
  end

  // Frame FSM, beat counter and status slot next-state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    status_d       = status_q;
    status_valid_d = status_valid_q & ~status_ready;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (input_axis_tlast) begin
            state_d        = ST_IDLE;
            status_d.len   = cnt_inc;
            status_d.flags = make_flags(1'b0, is_runt, input_axis_tuser);
            status_valid_d = 1'b1;
          end else if (hit_max) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DROP: begin
        if (accept && input_axis_tlast) begin
          state_d        = ST_IDLE;
          status_d.len   = MAX_L;
          status_d.flags = make_flags(1'b1, 1'b0, input_axis_tuser);
          status_valid_d = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and status slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= {LEN_WIDTH{1'b0}};
      status_q.len   <= {LEN_WIDTH{1'b0}};
      status_q.flags <= FLAGS_CLEAR;
      status_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
    end
  end

  axis_skid_reg #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   ({fwd_user, fwd_last, input_axis_tdata}),
    .in_valid_i  (accept & ~in_drop),
    .in_ready_o  (skid_ready),
    .out_data_o  (skid_out),
    .out_valid_o (output_axis_tvalid),
    .out_ready_i (output_axis_tready)
  );

  assign output_axis_tdata = skid_out[DATA_WIDTH-1:0];
  assign output_axis_tlast = skid_out[DATA_WIDTH];
  assign output_axis_tuser = skid_out[DATA_WIDTH+1];

  assign status_valid     = status_valid_q;
  assign status_frame_len = status_q.len;
  assign status_truncated = status_q.flags.truncated;
  assign status_runt      = status_q.flags.runt;
  assign status_bad       = status_q.flags.bad;

endmodule
